// File: rtl/rgb_stream_packer_if.sv
// Pixel-side and VDMA-side buses for the RGB stream packer.
`timescale 1ns/1ps

interface pix_stream_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       in_stream_ready;

    modport master (
        output r,
        output g,
        output b,
        output valid,
        output sof,
        output eol,
        input  in_stream_ready
    );

    modport slave (
        input  r,
        input  g,
        input  b,
        input  valid,
        input  sof,
        input  eol,
        output in_stream_ready
    );
endinterface

interface axis_video_if;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport master (
        output out_stream_tdata,
        output out_stream_tkeep,
        output out_stream_tlast,
        output out_stream_tuser,
        output out_stream_tvalid,
        input  out_stream_tready
    );

    modport slave (
        input  out_stream_tdata,
        input  out_stream_tkeep,
        input  out_stream_tlast,
        input  out_stream_tuser,
        input  out_stream_tvalid,
        output out_stream_tready
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels four-per-three into 32-bit AXI4-Stream words,
// carrying frame-start on tuser and line-end on tlast.
`timescale 1ns/1ps

module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic          aclk,
    input  logic          areset,
    pix_stream_if.slave   pix,
    axis_video_if.master  vid
);

    typedef enum logic {
        RUN,
        FLUSH
    } mode_t;

    mode_t       mode_q;
    mode_t       mode_n;
    logic [1:0]  phase_q;
    logic [1:0]  phase_n;
    logic [23:0] hold_q;
    logic [23:0] hold_n;
    logic        sof_pend_q;
    logic        sof_pend_n;
    logic        flush_two_q;
    logic        flush_two_n;

    logic [31:0] tdata_q;
    logic        tlast_q;
    logic        tuser_q;
    logic        tvalid_q;

    logic        free;
    logic        ready;
    logic        accept;
    logic [23:0] pixel;
    logic [1:0]  eff_phase;

    logic        emit;
    logic [31:0] word;
    logic        last;
    logic        user;

    assign free   = !tvalid_q || vid.out_stream_tready;
    assign ready  = free && (mode_q == RUN) && !areset;
    assign accept = pix.valid && ready;
    assign pixel  = {pix.r, pix.g, pix.b};

    // sof mid-group restarts packing, abandoning the partial bytes
    assign eff_phase = pix.sof ? 2'd0 : phase_q;

    assign pix.in_stream_ready = ready;

    always_comb begin
        mode_n      = mode_q;
        phase_n     = phase_q;
        hold_n      = hold_q;
        flush_two_n = flush_two_q;
        sof_pend_n  = sof_pend_q;
        emit        = 1'b0;
        word        = 32'h0;
        last        = 1'b0;
        user        = 1'b0;

        if (mode_q == FLUSH) begin
            if (free) begin
                emit    = 1'b1;
                last    = 1'b1;
                mode_n  = RUN;
                phase_n = 2'd0;
                if (flush_two_q) begin
                    word = {PAD_BYTE, PAD_BYTE, hold_q[15:0]};
                end else begin
                    word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, hold_q[7:0]};
                end
            end
        end else if (accept) begin
            unique case (eff_phase)
                2'd0: begin
                    hold_n = pixel;
                    if (pix.eol) begin
                        emit    = 1'b1;
                        word    = {PAD_BYTE, pixel};
                        last    = 1'b1;
                        phase_n = 2'd0;
                    end else begin
                        phase_n = 2'd1;
                    end
                end
                2'd1: begin
                    emit   = 1'b1;
                    word   = {pixel[7:0], hold_q};
                    hold_n = {hold_q[23:16], pixel[23:8]};
                    if (pix.eol) begin
                        mode_n      = FLUSH;
                        flush_two_n = 1'b1;
                        phase_n     = 2'd0;
                    end else begin
                        phase_n = 2'd2;
                    end
                end
                2'd2: begin
                    emit   = 1'b1;
                    word   = {pixel[15:0], hold_q[15:0]};
                    hold_n = {hold_q[23:8], pixel[23:16]};
                    if (pix.eol) begin
                        mode_n      = FLUSH;
                        flush_two_n = 1'b0;
                        phase_n     = 2'd0;
                    end else begin
                        phase_n = 2'd3;
                    end
                end
                2'd3: begin
                    emit    = 1'b1;
                    word    = {pixel, hold_q[7:0]};
                    last    = pix.eol;
                    phase_n = 2'd0;
                end
            endcase
        end

        // a same-cycle sof can tag the word it produces (eol at phase 0)
        user = sof_pend_q || (accept && pix.sof);
        if (emit) begin
            sof_pend_n = 1'b0;
        end else if (accept && pix.sof) begin
            sof_pend_n = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mode_q      <= RUN;
            phase_q     <= 2'd0;
            hold_q      <= 24'h0;
            sof_pend_q  <= 1'b0;
            flush_two_q <= 1'b0;
        end else begin
            mode_q      <= mode_n;
            phase_q     <= phase_n;
            hold_q      <= hold_n;
            sof_pend_q  <= sof_pend_n;
            flush_two_q <= flush_two_n;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= 32'h0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else if (free) begin
            tvalid_q <= emit;
            if (emit) begin
                tdata_q <= word;
                tlast_q <= last;
                tuser_q <= user;
            end
        end
    end

    assign vid.out_stream_tdata  = tdata_q;
    assign vid.out_stream_tkeep  = 4'hF;
    assign vid.out_stream_tlast  = tlast_q;
    assign vid.out_stream_tuser  = tuser_q;
    assign vid.out_stream_tvalid = tvalid_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed self-checking bench for rgb_stream_packer.
`timescale 1ns/1ps

module tb_rgb_stream_packer;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    pix_stream_if pix ();
    axis_video_if vid ();

    rgb_stream_packer #(
        .PAD_BYTE(8'h00)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .pix   (pix),
        .vid   (vid)
    );

    int checks = 0;
    int errors = 0;
    logic [37:0] got_q[$];
    logic [7:0]  exp_bytes[$];
    bit frame_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // a word seen valid+ready here is consumed at the next rising edge
    always @(negedge aclk) begin
        if (vid.out_stream_tvalid === 1'b1 && vid.out_stream_tready === 1'b1)
            got_q.push_back({vid.out_stream_tkeep, vid.out_stream_tuser,
                             vid.out_stream_tlast, vid.out_stream_tdata});
    end

    always @(posedge aclk) begin
        if (frame_on) begin
            #1;
            vid.out_stream_tready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drive(input logic [23:0] p, input logic s, input logic e);
        bit acc;
        acc = 1'b0;
        {pix.r, pix.g, pix.b} = p;
        pix.sof = s;
        pix.eol = e;
        pix.valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge aclk);
            acc = (pix.in_stream_ready === 1'b1);
            @(posedge aclk);
            #1;
        end
        pix.valid = 1'b0;
        pix.sof = 1'b0;
        pix.eol = 1'b0;
        if (!acc) check("accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) begin
            @(posedge aclk);
            #1;
        end
        check(tag, 64'(got_q.size()), 64'(n));
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic u, input logic l);
        logic [37:0] w;
        w = '0;
        if (got_q.size() > 0) w = got_q.pop_front();
        check(tag, 64'(w), 64'({4'hF, u, l, d}));
    endtask

    function automatic logic [23:0] pix_val(input int idx);
        logic [15:0] v;
        v = idx[15:0];
        return {v[7:0], v[15:8] ^ 8'h5A, v[7:0] + 8'h3C};
    endfunction

    int zeros;
    logic [31:0] d;

    initial begin
        pix.r = 8'h0;
        pix.g = 8'h0;
        pix.b = 8'h0;
        pix.valid = 1'b0;
        pix.sof = 1'b0;
        pix.eol = 1'b0;
        vid.out_stream_tready = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // leave a word stuck in the output register, then reset over it
        vid.out_stream_tready = 1'b0;
        drive(24'hAAAAAA, 1'b0, 1'b0);
        drive(24'hBBBBBB, 1'b0, 1'b0);
        check("pend_tvalid", 64'(vid.out_stream_tvalid), 64'd1);
        areset = 1'b1;
        {pix.r, pix.g, pix.b} = 24'hDEADBE;
        pix.valid = 1'b1;
        @(posedge aclk);
        #1;
        vid.out_stream_tready = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("rst_tvalid", 64'(vid.out_stream_tvalid), 64'd0);
            check("rst_ready", 64'(pix.in_stream_ready), 64'd0);
            @(posedge aclk);
            #1;
        end
        areset = 1'b0;
        pix.valid = 1'b0;
        check("rst_tdata", 64'(vid.out_stream_tdata), 64'd0);
        idle(2);
        check("rst_drop", 64'(got_q.size()), 64'd0);

        // basic group, first pixel after reset must pack as phase 0
        drive(24'h112233, 1'b1, 1'b0);
        drive(24'h445566, 1'b0, 1'b0);
        drive(24'h778899, 1'b0, 1'b0);
        drive(24'hAABBCC, 1'b0, 1'b1);
        wait_words("basic_n", 3, 50);
        expect_word("basic_w0", 32'h66112233, 1'b1, 1'b0);
        expect_word("basic_w1", 32'h88994455, 1'b0, 1'b0);
        expect_word("basic_w2", 32'hAABBCC77, 1'b0, 1'b1);
        idle(3);
        check("basic_extra", 64'(got_q.size()), 64'd0);

        // back-pressure: stall after the first word
        vid.out_stream_tready = 1'b0;
        fork
            begin
                drive(24'h112233, 1'b1, 1'b0);
                drive(24'h445566, 1'b0, 1'b0);
                drive(24'h778899, 1'b0, 1'b0);
                drive(24'hAABBCC, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 100 && vid.out_stream_tvalid !== 1'b1; i++)
                    @(negedge aclk);
                check("bp_seen", 64'(vid.out_stream_tvalid), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    check("bp_data", 64'(vid.out_stream_tdata), 64'h66112233);
                    check("bp_ready", 64'(pix.in_stream_ready), 64'd0);
                    @(negedge aclk);
                end
                @(posedge aclk);
                #1;
                vid.out_stream_tready = 1'b1;
            end
        join
        wait_words("bp_n", 3, 50);
        expect_word("bp_w0", 32'h66112233, 1'b1, 1'b0);
        expect_word("bp_w1", 32'h88994455, 1'b0, 1'b0);
        expect_word("bp_w2", 32'hAABBCC77, 1'b0, 1'b1);
        idle(3);
        check("bp_extra", 64'(got_q.size()), 64'd0);

        // flush after eol at phase 1
        drive(24'h112233, 1'b0, 1'b0);
        drive(24'h445566, 1'b0, 1'b1);
        zeros = 0;
        repeat (6) begin
            @(negedge aclk);
            if (pix.in_stream_ready !== 1'b1) zeros++;
            @(posedge aclk);
            #1;
        end
        check("flush_stall", 64'(zeros), 64'd1);
        wait_words("flush_n", 2, 50);
        expect_word("flush_w0", 32'h66112233, 1'b0, 1'b0);
        expect_word("flush_w1", 32'h00004455, 1'b0, 1'b1);

        // sof+eol on a lone pixel at phase 0
        drive(24'hC1C2C3, 1'b1, 1'b1);
        wait_words("eol0_n", 1, 50);
        expect_word("eol0_w", 32'h00C1C2C3, 1'b1, 1'b1);

        // sof arriving at phase 2 drops the partial bytes
        drive(24'hA1A2A3, 1'b0, 1'b0);
        drive(24'hB1B2B3, 1'b0, 1'b0);
        drive(24'h010203, 1'b1, 1'b0);
        drive(24'h040506, 1'b0, 1'b1);
        wait_words("sof2_n", 3, 50);
        expect_word("sof2_w0", 32'hB3A1A2A3, 1'b0, 1'b0);
        expect_word("sof2_w1", 32'h06010203, 1'b1, 1'b0);
        expect_word("sof2_w2", 32'h00000405, 1'b0, 1'b1);
        idle(3);
        check("sof2_extra", 64'(got_q.size()), 64'd0);

        // two 640-pixel lines under random back-pressure
        frame_on = 1'b1;
        for (int ln = 0; ln < 2; ln++) begin
            for (int x = 0; x < 640; x++) begin
                logic [23:0] p;
                p = pix_val(ln * 640 + x);
                exp_bytes.push_back(p[7:0]);
                exp_bytes.push_back(p[15:8]);
                exp_bytes.push_back(p[23:16]);
                drive(p, (ln == 0 && x == 0), (x == 639));
            end
        end
        frame_on = 1'b0;
        idle(1);
        vid.out_stream_tready = 1'b1;
        wait_words("frame_n", 960, 5000);
        idle(3);
        check("frame_total", 64'(got_q.size()), 64'd960);
        for (int i = 0; i < 960; i++) begin
            d = '0;
            for (int k = 0; k < 4; k++)
                if (exp_bytes.size() > 0) d[k*8 +: 8] = exp_bytes.pop_front();
            expect_word($sformatf("frame_w%0d", i + 1), d, (i == 0),
                        (i == 479 || i == 959));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
